sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock FIFO for buffering commands and data inside one clock domain of the GPU (e.g. command decode to rasteriser, SRAM request queues).
- Generalises the dual-clock command FIFO to one clock, keeping its boot pre-population.
- Adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush.

Parameters:
- WIDTH, 72: data width in bits.
- DEPTH, 32: entries; power of 2, at least 4.
- ADDR_WIDTH, $clog2(DEPTH): derived; do not override.
- BOOT_COUNT, 0: entries readable immediately after reset; must be 0 to DEPTH. Contents are initialised externally.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= this value.
- AEMPTY_THRESH, 2: almost_empty asserts when count <= this value.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- rd_en  in  1  read request (FWFT: pop/acknowledge).
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data is valid.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0 to DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset takes effect on the clock edge where rst=1. State after that edge:
  - wr_ptr = BOOT_COUNT, rd_ptr = 0, count = BOOT_COUNT.
  - overflow = 0, underflow = 0, rd_data = 0.
  - rd_valid = 0 in standard mode; rd_valid = (BOOT_COUNT>0) in FWFT mode.
  - Memory contents are untouched.
  - Reset overrides flush, wr_en and rd_en.
- Pointers are ADDR_WIDTH+1 bits. Memory index = ptr[ADDR_WIDTH-1:0]. Wrap-around is natural modulo 2^(ADDR_WIDTH+1).
- count is a registered counter, equal to wr_ptr - rd_ptr. full, empty, almost_full and almost_empty decode combinationally from the registered count.
- Write accept: wr_acc = wr_en & ~full.
  - Memory is written at wr_ptr; wr_ptr increments.
  - A write while full is dropped and sets overflow.
  - No write-through when full, even if a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en & ~empty. A read while empty is ignored and sets underflow.
  - No read-through when empty: a write to an empty FIFO is not readable in the same cycle.
- Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 on the next edge. Latency is 1 cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]], read combinationally; rd_valid = ~empty.
  - rd_en acts as a pop. Data written into an empty FIFO appears with rd_valid=1 on the cycle after the write.
- Flush (rst=0, flush=1):
  - Next edge: wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0, rd_valid = 0.
  - Ignores BOOT_COUNT.
  - Overrides wr_en and rd_en in the same cycle; nothing is written.
  - rd_data holds its last value.
- Sticky flags clear only on rst or flush.
- Flag update order per cycle: rst > flush > (write, read).

Test Plan:
1. BOOT_COUNT=4, FWFT=0, memory preloaded 0xA0..0xA3.
   - Release rst, then rd_en for 4 cycles → count 4,3,2,1,0.
   - rd_data 0xA0..0xA3, each with rd_valid one cycle after its rd_en.
   - empty=1 after the 4th read.
2. DEPTH=8, FWFT=1.
   - Write 0x11 to an empty FIFO → next cycle rd_valid=1, rd_data=0x11, count=1.
   - rd_en → following cycle empty=1, rd_valid=0.
3. DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2.
   - Write 8 words → almost_full rises at count=6; full at count=8.
   - 9th write → dropped, overflow=1, count stays 8.
   - Read all 8 → data in order; almost_empty at count<=2.
4. Full FIFO with wr_en and rd_en in the same cycle → write dropped, read accepted, count=7, overflow=1.
   - Count=3 with simultaneous wr and rd → count stays 3; wr_ptr and rd_ptr both advance.
5. rd_en on an empty FIFO → underflow=1, rd_valid stays 0.
   - Then flush with wr_en=1 → count=0, underflow=0, overflow=0, nothing written.
   - Then 40 write/read pairs → pointers wrap past 2*DEPTH and data stays in order.
6. rst asserted mid-stream at count=5, with rd_en and flush also high → next cycle count=BOOT_COUNT, rd_valid per mode, flags 0.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with boot pre-population, optional first-word-fall-through
// read port, almost-full/empty thresholds, sticky error flags and sync flush.
module sync_fifo #(
  parameter int WIDTH         = 72,
  parameter int DEPTH         = 32,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int BOOT_COUNT    = 0,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] BOOT_PTR = (ADDR_WIDTH+1)'(BOOT_COUNT);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_acc, rd_acc, mem_we;
  logic                full_w, empty_w;

  assign full_w       = (count_q == DEPTH_C);
  assign empty_w      = (count_q == '0);
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wr_acc     = wr_en & ~full_w;
    rd_acc     = rd_en & ~empty_w;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      mem_we = wr_acc;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        rd_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
      if (wr_en & full_w)  ovf_d = 1'b1;
      if (rd_en & empty_w) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= BOOT_PTR;
      rd_ptr_q   <= '0;
      count_q    <= BOOT_PTR;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage has no reset so boot contents loaded externally survive rst.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign rd_valid = ~empty_w;
  end else begin : g_std
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT instances share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int BC = 4;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;

  logic          s_full, s_afull, s_rd_valid, s_empty, s_aempty, s_ovf, s_unf;
  logic [W-1:0]  s_rd_data;
  logic [AW:0]   s_count;
  logic          f_full, f_afull, f_rd_valid, f_empty, f_aempty, f_ovf, f_unf;
  logic [W-1:0]  f_rd_data;
  logic [AW:0]   f_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] shadow_mem [D];
  int           wr_pos = 0;
  bit           m_ovf = 0, m_unf = 0, m_sv = 0;
  logic [W-1:0] m_sd = '0;
  bit           data_ok = 0;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(W), .DEPTH(D), .BOOT_COUNT(BC), .FWFT(0),
              .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_afull), .rd_en(rd_en), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_aempty),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(.WIDTH(W), .DEPTH(D), .BOOT_COUNT(BC), .FWFT(1),
              .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_aempty),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit f, input bit we,
                            input logic [W-1:0] wd, input bit re);
    int occ;
    bit acc_w, acc_r;
    if (r) begin
      exp_q.delete();
      for (int i = 0; i < BC; i++) exp_q.push_back(shadow_mem[i]);
      wr_pos = BC % D;
      m_ovf = 0; m_unf = 0; m_sd = '0; m_sv = 0;
    end else if (f) begin
      exp_q.delete();
      wr_pos = 0;
      m_ovf = 0; m_unf = 0; m_sv = 0;
      data_ok = 1;
    end else begin
      occ   = exp_q.size();
      acc_w = we && (occ < D);
      acc_r = re && (occ > 0);
      if (we && occ == D) m_ovf = 1;
      if (re && occ == 0) m_unf = 1;
      m_sv = acc_r;
      if (acc_r) m_sd = exp_q.pop_front();
      if (acc_w) begin
        exp_q.push_back(wd);
        shadow_mem[wr_pos] = wd;
        wr_pos = (wr_pos + 1) % D;
      end
    end
  endtask

  task automatic check_outputs();
    int occ;
    occ = exp_q.size();
    chk("s_count", 32'(s_count), 32'(occ));
    chk("f_count", 32'(f_count), 32'(occ));
    chk("s_full",  32'(s_full),  32'(occ == D));
    chk("f_full",  32'(f_full),  32'(occ == D));
    chk("s_empty", 32'(s_empty), 32'(occ == 0));
    chk("f_empty", 32'(f_empty), 32'(occ == 0));
    chk("s_afull", 32'(s_afull), 32'(occ >= AF));
    chk("f_afull", 32'(f_afull), 32'(occ >= AF));
    chk("s_aempty", 32'(s_aempty), 32'(occ <= AE));
    chk("f_aempty", 32'(f_aempty), 32'(occ <= AE));
    chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
    chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("s_unf", 32'(s_unf), 32'(m_unf));
    chk("f_unf", 32'(f_unf), 32'(m_unf));
    chk("s_rd_valid", 32'(s_rd_valid), 32'(m_sv));
    chk("s_rd_data",  32'(s_rd_data),  32'(m_sd));
    chk("f_rd_valid", 32'(f_rd_valid), 32'(occ > 0));
    if (occ > 0 && data_ok) chk("f_rd_data", 32'(f_rd_data), 32'(exp_q[0]));
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input bit r, input bit f, input bit we,
                      input logic [W-1:0] wd, input bit re);
    rst = r; flush = f; wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk);
    model_step(r, f, we, wd, re);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wr(input logic [W-1:0] wd);
    step(0, 0, 1, wd, 0);
  endtask

  task automatic rd();
    step(0, 0, 0, '0, 1);
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    chk("boot_count", 32'(s_count), 32'(BC));
    chk("boot_f_valid", 32'(f_rd_valid), 32'd1);
    step(0, 1, 0, '0, 0);
    chk("flush_count", 32'(s_count), 32'd0);

    // Boot pre-population: load A0..A3 at indices 0..3, then reset over them
    for (int i = 0; i < 4; i++) wr(W'(16'h00A0 + i));
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      rd();
      chk("boot_rd_data", 32'(s_rd_data), 32'(16'h00A0 + i));
      chk("boot_rd_cnt", 32'(s_count), 32'(3 - i));
    end
    chk("boot_empty", 32'(s_empty), 32'd1);
    step(0, 0, 0, '0, 0);

    // FWFT fall-through
    wr(16'h0011);
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_data", 32'(f_rd_data), 32'h11);
    rd();
    chk("fwft_empty", 32'(f_empty), 32'd1);

    // Fill, overflow, simultaneous access at full and mid-level
    for (int i = 0; i < D; i++) wr(W'(16'h0100 + i));
    wr(16'hDEAD);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_count", 32'(s_count), 32'(D));
    step(0, 0, 1, 16'hBEEF, 1);
    chk("full_wr_rd_count", 32'(s_count), 32'd7);
    for (int i = 0; i < 4; i++) rd();
    step(0, 0, 1, 16'h0333, 1);
    chk("mid_wr_rd_count", 32'(s_count), 32'd3);
    for (int i = 0; i < 3; i++) rd();

    // Underflow, flush overriding a write, pointer wrap
    rd();
    chk("unf_set", 32'(s_unf), 32'd1);
    step(0, 1, 1, 16'h7777, 0);
    chk("flush_unf", 32'(s_unf), 32'd0);
    wr(16'h1000);
    for (int i = 0; i < 40; i++) step(0, 0, 1, W'(16'h2000 + i), 1);
    rd();

    // Reset mid-stream overrides flush and rd_en
    for (int i = 0; i < 5; i++) wr(W'(16'h3000 + i));
    step(1, 1, 0, '0, 1);
    chk("rst_mid_count", 32'(s_count), 32'(BC));

    // Randomised traffic with varying bias
    for (int ph = 0; ph < 15; ph++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        bit r, f, we, re;
        r  = ($urandom_range(0, 299) == 0);
        f  = ($urandom_range(0, 149) == 0);
        we = ($urandom_range(0, 99) < wp);
        re = ($urandom_range(0, 99) < rp);
        step(r, f, we, W'($urandom_range(0, 16'hFFFF)), re);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
